// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, sequenced IDLE/ISSUE/WAIT/RESP.
// Define LSU_RVFI_EN to add the rvfi_mem_* retirement trace outputs.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [29:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
`ifdef LSU_RVFI_EN
  ,
  output logic [31:0] rvfi_mem_addr,
  output logic [3:0]  rvfi_mem_rmask,
  output logic [3:0]  rvfi_mem_wmask,
  output logic [31:0] rvfi_mem_rdata,
  output logic [31:0] rvfi_mem_wdata
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic req_illegal(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (ld == st) begin
      bad = 1'b1;
    end else begin
      case (f3)
        3'd0:    bad = 1'b0;
        3'd1:    bad = off[0];
        3'd2:    bad = (off != 2'd0);
        3'd4:    bad = st;
        3'd5:    bad = st | off[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = 4'b0011 << off;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    r = {{24{sh[7]}}, sh[7:0]};
      3'd1:    r = {{16{sh[15]}}, sh[15:0]};
      3'd2:    r = sh;
      3'd4:    r = {24'd0, sh[7:0]};
      3'd5:    r = {16'd0, sh[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic        load_q, load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;
`ifdef LSU_RVFI_EN
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rvfi_addr_q, rvfi_addr_d, rvfi_rdata_q, rvfi_rdata_d, rvfi_wdata_q, rvfi_wdata_d;
  logic [3:0]  rvfi_rmask_q, rvfi_rmask_d, rvfi_wmask_q, rvfi_wmask_d;
`endif

  // Next-state and output computation; memory strobes and resp_valid are single-cycle pulses.
  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = 30'd0;
    mem_wdata_d  = 32'd0;
    mem_wstrb_d  = 4'd0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
`ifdef LSU_RVFI_EN
    req_addr_d   = req_addr_q;
    rvfi_addr_d  = 32'd0;
    rvfi_rdata_d = 32'd0;
    rvfi_wdata_d = 32'd0;
    rvfi_rmask_d = 4'd0;
    rvfi_wmask_d = 4'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load_d   = req_load;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
`ifdef LSU_RVFI_EN
          req_addr_d = req_addr;
`endif
          if (req_illegal(req_load, req_store, req_funct3, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'd0;
          end else begin
            state_d     = ST_ISSUE;
            mem_read_d  = req_load;
            mem_write_d = req_store;
            mem_addr_d  = req_addr[31:2];
            if (req_store) begin
              mem_wstrb_d = lane_mask(req_funct3[1:0], req_addr[1:0]);
              mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            end else begin
              mem_wstrb_d = 4'd0;
              mem_wdata_d = 32'd0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (load_q) begin
          state_d = ST_WAIT;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'd0;
`ifdef LSU_RVFI_EN
          rvfi_addr_d  = req_addr_q;
          rvfi_wmask_d = mem_wstrb_q;
          rvfi_wdata_d = mem_wdata_q;
`endif
        end
      end
      ST_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = load_extend(funct3_q, mem_rdata, off_q);
`ifdef LSU_RVFI_EN
        rvfi_addr_d  = req_addr_q;
        rvfi_rmask_d = lane_mask(funct3_q[1:0], off_q);
        rvfi_rdata_d = mem_rdata;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      load_q       <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 30'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'd0;
`ifdef LSU_RVFI_EN
      req_addr_q   <= 32'd0;
      rvfi_addr_q  <= 32'd0;
      rvfi_rdata_q <= 32'd0;
      rvfi_wdata_q <= 32'd0;
      rvfi_rmask_q <= 4'd0;
      rvfi_wmask_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
`ifdef LSU_RVFI_EN
      req_addr_q   <= req_addr_d;
      rvfi_addr_q  <= rvfi_addr_d;
      rvfi_rdata_q <= rvfi_rdata_d;
      rvfi_wdata_q <= rvfi_wdata_d;
      rvfi_rmask_q <= rvfi_rmask_d;
      rvfi_wmask_q <= rvfi_wmask_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
`ifdef LSU_RVFI_EN
  assign rvfi_mem_addr  = rvfi_addr_q;
  assign rvfi_mem_rmask = rvfi_rmask_q;
  assign rvfi_mem_wmask = rvfi_wmask_q;
  assign rvfi_mem_rdata = rvfi_rdata_q;
  assign rvfi_mem_wdata = rvfi_wdata_q;
`endif

endmodule
